// File: rtl/llsc_commit_queue_pkg.sv
// Shared types for the LL/SC commit queue: op codes, queue entry and writeback record.
package llsc_commit_queue_pkg;

  localparam logic [5:0] OpIdle = 6'h00;
  localparam logic [5:0] OpLdqL = 6'h2b;
  localparam logic [5:0] OpStq  = 6'h2d;
  localparam logic [5:0] OpStqC = 6'h2f;

  // Entries carry the widest supported tag; the top level narrows it to TAG_WIDTH.
  localparam int unsigned MaxTagWidth = 16;

  typedef struct packed {
    logic [5:0]             op_type;
    logic [63:0]            addr;
    logic [MaxTagWidth-1:0] dest_tag;
    logic                   thread;
  } cq_entry_t;

  typedef struct packed {
    logic                   valid;
    logic [MaxTagWidth-1:0] dest_tag;
    logic                   thread;
    logic                   success;
  } cq_wb_t;

  function automatic logic is_llsc_op(input logic [5:0] op);
    return (op == OpLdqL) || (op == OpStqC) || (op == OpStq);
  endfunction

endpackage

// File: rtl/llsc_cq_fifo.sv
// Two-write / one-read circular FIFO with an explicit occupancy count.
module llsc_cq_fifo
  import llsc_commit_queue_pkg::*;
#(
  parameter  int unsigned Depth = 8,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      push_num,
  input  cq_entry_t [1:0] push_data,
  input  logic            pop,
  output cq_entry_t       head,
  output logic [CntW-1:0] count
);

  cq_entry_t       mem_q [Depth];
  logic [PtrW-1:0] head_q, tail_q, tail_inc;
  logic [CntW-1:0] count_q;

  assign tail_inc = tail_q + PtrW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        head_q <= head_q + PtrW'(1);
      end
      tail_q  <= tail_q + PtrW'(push_num);
      count_q <= count_q + CntW'(push_num) - CntW'(pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (push_num != 2'd0) begin
      mem_q[tail_q] <= push_data[0];
    end
    if (push_num == 2'd2) begin
      mem_q[tail_inc] <= push_data[1];
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/llsc_commit_queue.sv
// LL/SC commit queue: filters retired ops, issues one per cycle, writes back STQ_C results.
// Optional macro LLSC_FULL_STALL_EN holds an LDQ_L at the head while the table is full.
module llsc_commit_queue
  import llsc_commit_queue_pkg::*;
#(
  parameter  int unsigned QUEUE_DEPTH = 8,
  parameter  int unsigned TAG_WIDTH   = 6,
  localparam int unsigned CntW        = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                in_valid,
  input  logic [1:0][5:0]           in_op_type,
  input  logic [1:0][63:0]          in_addr,
  input  logic [1:0][TAG_WIDTH-1:0] in_dest_tag,
  input  logic [1:0]                in_thread,
  output logic                      in_ready,
  output logic                      llsc_enable,
  output logic [5:0]                llsc_op_type,
  output logic [63:0]               llsc_mem_addr,
  input  logic                      llsc_store_success,
  input  logic                      llsc_full,
  output logic                      wb_valid,
  output logic [TAG_WIDTH-1:0]      wb_dest_tag,
  output logic                      wb_thread,
  output logic [63:0]               wb_value,
  output logic [CntW-1:0]           count
);

  cq_entry_t [1:0] slot;
  cq_entry_t [1:0] push_data;
  logic      [1:0] qual;
  logic      [1:0] push_num;
  cq_entry_t       head;
  logic            stall;
  logic            issue;
  cq_wb_t          wb_q, wb_d;

  assign in_ready = (count <= CntW'(QUEUE_DEPTH - 2));

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slot[i].op_type  = in_op_type[i];
      slot[i].addr     = in_addr[i];
      slot[i].dest_tag = MaxTagWidth'(in_dest_tag[i]);
      slot[i].thread   = in_thread[i];
      qual[i]          = in_valid[i] && in_ready && is_llsc_op(in_op_type[i]);
    end
    // Compact qualifying slots so the older one always lands at tail.
    push_data[0] = qual[0] ? slot[0] : slot[1];
    push_data[1] = slot[1];
    push_num     = {1'b0, qual[0]} + {1'b0, qual[1]};
  end

  llsc_cq_fifo #(
    .Depth (QUEUE_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_num  (push_num),
    .push_data (push_data),
    .pop       (issue),
    .head      (head),
    .count     (count)
  );

`ifdef LLSC_FULL_STALL_EN
  assign stall = (head.op_type == OpLdqL) && llsc_full;
`else
  logic unused_full;
  assign unused_full = llsc_full;
  assign stall       = 1'b0;
`endif

  assign issue = (count != '0) && !stall;

  always_comb begin
    llsc_enable   = issue;
    llsc_op_type  = OpIdle;
    llsc_mem_addr = '0;
    if (issue) begin
      llsc_op_type  = head.op_type;
      llsc_mem_addr = head.addr;
    end
  end

  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    if (issue && (head.op_type == OpStqC)) begin
      wb_d.valid    = 1'b1;
      wb_d.dest_tag = head.dest_tag;
      wb_d.thread   = head.thread;
      wb_d.success  = llsc_store_success;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  logic unused_tag_bits;
  assign unused_tag_bits = ^wb_q.dest_tag;

  assign wb_valid    = wb_q.valid;
  assign wb_dest_tag = wb_q.dest_tag[TAG_WIDTH-1:0];
  assign wb_thread   = wb_q.thread;
  assign wb_value    = {63'b0, wb_q.success};

endmodule

// File: tb/tb_llsc_commit_queue.sv
// Scoreboard bench for llsc_commit_queue against a queue-based reference model.
module tb_llsc_commit_queue;

  localparam int D  = 8;
  localparam int TW = 6;
  localparam logic [5:0] LDQ_L = 6'h2b;
  localparam logic [5:0] STQ_C = 6'h2f;
  localparam logic [5:0] STQ   = 6'h2d;
  localparam logic [5:0] LDQ   = 6'h29;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          in_valid;
  logic [1:0][5:0]     in_op_type;
  logic [1:0][63:0]    in_addr;
  logic [1:0][TW-1:0]  in_dest_tag;
  logic [1:0]          in_thread;
  logic                in_ready;
  logic                llsc_enable;
  logic [5:0]          llsc_op_type;
  logic [63:0]         llsc_mem_addr;
  logic                llsc_store_success;
  logic                llsc_full;
  logic                wb_valid;
  logic [TW-1:0]       wb_dest_tag;
  logic                wb_thread;
  logic [63:0]         wb_value;
  logic [3:0]          count;

  llsc_commit_queue #(
    .QUEUE_DEPTH (D),
    .TAG_WIDTH   (TW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_op_type         (in_op_type),
    .in_addr            (in_addr),
    .in_dest_tag        (in_dest_tag),
    .in_thread          (in_thread),
    .in_ready           (in_ready),
    .llsc_enable        (llsc_enable),
    .llsc_op_type       (llsc_op_type),
    .llsc_mem_addr      (llsc_mem_addr),
    .llsc_store_success (llsc_store_success),
    .llsc_full          (llsc_full),
    .wb_valid           (wb_valid),
    .wb_dest_tag        (wb_dest_tag),
    .wb_thread          (wb_thread),
    .wb_value           (wb_value),
    .count              (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]    op;
    logic [63:0]   addr;
    logic [TW-1:0] tag;
    logic          th;
  } ent_t;

  typedef struct {
    logic rdy;
    int   occ;
    logic en;
    logic wbv;
  } cyc_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic          th;
    logic          s;
  } wb_t;

  ent_t mq[$];
  ent_t exp_issue[$];
  cyc_t exp_cyc[$];
  wb_t  exp_wb[$];
  bit   wb_pend;
  int   n_cmp;
  int   n_err;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return (op == LDQ_L) || (op == STQ_C) || (op == STQ);
  endfunction

  // One clock cycle: drive inputs, advance the model, queue what the DUT must show.
  task automatic step(input logic [1:0] v, input logic [5:0] op0, input logic [5:0] op1,
                      input logic [63:0] a0, input logic [63:0] a1,
                      input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                      input logic [1:0] th, input logic full, input logic succ,
                      input logic rst);
    ent_t e;
    int   occ;
    bit   stall;
    bit   iss;
    bit   rdy;
    bit   wbn;
    in_valid           = v;
    in_op_type[0]      = op0;
    in_op_type[1]      = op1;
    in_addr[0]         = a0;
    in_addr[1]         = a1;
    in_dest_tag[0]     = t0;
    in_dest_tag[1]     = t1;
    in_thread          = th;
    llsc_full          = full;
    llsc_store_success = succ;
    reset              = rst;
    if (rst) begin
      mq.delete();
      exp_wb.delete();
      wb_pend = 1'b0;
    end else begin
      occ   = mq.size();
      rdy   = (D - occ) >= 2;
      stall = 1'b0;
`ifdef LLSC_FULL_STALL_EN
      if (occ > 0 && mq[0].op == LDQ_L && full) stall = 1'b1;
`endif
      iss = (occ > 0) && !stall;
      exp_cyc.push_back('{rdy: rdy, occ: occ, en: iss, wbv: wb_pend});
      wbn = 1'b0;
      if (iss) begin
        e = mq.pop_front();
        exp_issue.push_back(e);
        if (e.op == STQ_C) begin
          exp_wb.push_back('{tag: e.tag, th: e.th, s: succ});
          wbn = 1'b1;
        end
      end
      if (rdy) begin
        if (v[0] && legal(op0)) mq.push_back('{op: op0, addr: a0, tag: t0, th: th[0]});
        if (v[1] && legal(op1)) mq.push_back('{op: op1, addr: a1, tag: t1, th: th[1]});
      end
      wb_pend = wbn;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic full, input logic succ);
    for (int i = 0; i < n; i++) step(2'b00, 6'd0, 6'd0, 64'd0, 64'd0, '0, '0, 2'b00, full, succ, 1'b0);
  endtask

  function automatic logic [5:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 3) return LDQ_L;
    if (r < 5) return STQ_C;
    if (r < 7) return STQ;
    if (r < 8) return LDQ;
    return 6'($urandom_range(0, 63));
  endfunction

  // Monitor: compare whatever the DUT presents this cycle against the scoreboard.
  initial begin
    cyc_t c;
    ent_t e;
    wb_t  w;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        if (exp_cyc.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL cycle_expect: got none, expected a cycle record at %0t", $time);
        end else begin
          c = exp_cyc.pop_front();
          check("in_ready", 64'(in_ready), 64'(c.rdy));
          check("count", 64'(count), 64'(c.occ));
          check("llsc_enable", 64'(llsc_enable), 64'(c.en));
          check("wb_valid", 64'(wb_valid), 64'(c.wbv));
        end
        if (llsc_enable === 1'b1) begin
          if (exp_issue.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_unexpected: got op 0x%0h, expected no issue at %0t",
                     llsc_op_type, $time);
          end else begin
            e = exp_issue.pop_front();
            check("issue_op", 64'(llsc_op_type), 64'(e.op));
            check("issue_addr", llsc_mem_addr, e.addr);
          end
        end else begin
          check("idle_op", 64'(llsc_op_type), 64'd0);
          check("idle_addr", llsc_mem_addr, 64'd0);
        end
        if (wb_valid === 1'b1) begin
          if (exp_wb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_unexpected: got tag 0x%0h, expected no writeback at %0t",
                     wb_dest_tag, $time);
          end else begin
            w = exp_wb.pop_front();
            check("wb_tag", 64'(wb_dest_tag), 64'(w.tag));
            check("wb_thread", 64'(wb_thread), 64'(w.th));
            check("wb_value", wb_value, 64'(w.s));
          end
        end
      end
    end
  end

  initial begin
    int          dens;
    logic [1:0]  v;
    logic [5:0]  o0, o1;
    reset              = 1'b1;
    in_valid           = '0;
    in_op_type         = '0;
    in_addr            = '0;
    in_dest_tag        = '0;
    in_thread          = '0;
    llsc_full          = 1'b0;
    llsc_store_success = 1'b0;
    n_cmp              = 0;
    n_err              = 0;
    wb_pend            = 1'b0;
    @(posedge clock);
    #1;
    idle(0, 1'b0, 1'b0);
    step(2'b00, 6'd0, 6'd0, 64'd0, 64'd0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b00, 6'd0, 6'd0, 64'd0, 64'd0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1);

    // STQ_C issue and success writeback
    step(2'b01, STQ_C, 6'd0, 64'h100, 64'd0, 6'd5, '0, 2'b01, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);
    // LDQ_L then STQ in one cycle, no writeback
    step(2'b11, LDQ_L, STQ, 64'h40, 64'h80, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    // Plain load in slot 0 is filtered out
    step(2'b11, LDQ, STQ_C, 64'h300, 64'h200, 6'd1, 6'd9, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    // LDQ_L at head against a full table for four cycles
    step(2'b01, LDQ_L, 6'd0, 64'h500, 64'd0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b0);
    // Reset with ops queued and an STQ_C writeback pending
    step(2'b11, STQ_C, STQ_C, 64'h600, 64'h608, 6'd3, 6'd4, 2'b10, 1'b0, 1'b0, 1'b0);
    step(2'b11, LDQ_L, LDQ_L, 64'h700, 64'h708, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b00, 6'd0, 6'd0, 64'd0, 64'd0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);

    // Randomized traffic with density bursts to fill and wrap the queue repeatedly
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 0) dens = int'($urandom_range(0, 4));
      v[0] = $urandom_range(0, 3) < dens;
      v[1] = $urandom_range(0, 3) < dens;
      o0   = rand_op();
      o1   = rand_op();
      step(v, o0, o1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
           TW'($urandom()), TW'($urandom()), 2'($urandom()),
           $urandom_range(0, 3) == 0, 1'($urandom()), $urandom_range(0, 199) == 0);
    end

    idle(2 * D + 4, 1'b0, 1'b0);
    check("issue_drained", 64'(exp_issue.size()), 64'd0);
    check("wb_drained", 64'(exp_wb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
